// File: rtl/rename_reg_file_pkg.sv
// Shared bus widths and payload types for the rename register file.
// Contents: data/address/RSID widths, REG_ZERO, and the read-response payload struct.
package rename_reg_file_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned RSID_BUS_W = 5;

    typedef logic [DATA_W-1:0]     data_bus_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;
    typedef logic [RSID_BUS_W-1:0] rsid_bus_t;

    localparam reg_addr_bus_t REG_ZERO = 5'd0;

    // One read-port answer: either a committed value or a zero-extended RSID.
    typedef struct packed {
        logic      is_rsid;
        data_bus_t data;
    } rd_resp_t;

endpackage

// File: rtl/rename_reg_file_if.sv
// Bus bundle between the ID stage / ROB (master) and the rename register file (slave).
// Carries two read ports, one destination allocation, one commit and a flush.
interface rename_reg_file_if #(
    parameter int unsigned RSID_WIDTH = 5
);
    import rename_reg_file_pkg::*;

    logic                  read_en_1;
    reg_addr_bus_t         read_addr_1;
    logic                  read_is_rsid_1;
    data_bus_t             read_data_1;
    logic                  read_en_2;
    reg_addr_bus_t         read_addr_2;
    logic                  read_is_rsid_2;
    data_bus_t             read_data_2;

    logic                  alloc_en;
    reg_addr_bus_t         alloc_addr;
    logic [RSID_WIDTH-1:0] alloc_rsid;

    logic                  commit_en;
    reg_addr_bus_t         commit_addr;
    logic [RSID_WIDTH-1:0] commit_rsid;
    data_bus_t             commit_data;

    logic                  flush;

    modport master (
        output read_en_1, read_addr_1, read_en_2, read_addr_2,
        output alloc_en, alloc_addr, alloc_rsid,
        output commit_en, commit_addr, commit_rsid, commit_data,
        output flush,
        input  read_is_rsid_1, read_data_1, read_is_rsid_2, read_data_2
    );

    modport slave (
        input  read_en_1, read_addr_1, read_en_2, read_addr_2,
        input  alloc_en, alloc_addr, alloc_rsid,
        input  commit_en, commit_addr, commit_rsid, commit_data,
        input  flush,
        output read_is_rsid_1, read_data_1, read_is_rsid_2, read_data_2
    );

endinterface

// File: rtl/rename_reg_file_reg_read_port.sv
// reg_read_port: combinational lookup of one register entry, with optional
// same-cycle commit bypass (enabled by defining REGFILE_COMMIT_BYPASS_EN).
// Ports: i_rst (active-low, forces zero output), i_en/i_addr (request),
//        i_value/i_busy/i_tag (entry state), i_commit_* (commit bus),
//        o_resp (is_rsid + data).
module reg_read_port
    import rename_reg_file_pkg::*;
#(
    parameter int unsigned RSID_WIDTH = RSID_BUS_W
) (
    input  logic                  i_rst,
    input  logic                  i_en,
    input  reg_addr_bus_t         i_addr,
    input  data_bus_t             i_value [NUM_REGS],
    input  logic [NUM_REGS-1:0]   i_busy,
    input  logic [RSID_WIDTH-1:0] i_tag   [NUM_REGS],
    input  logic                  i_commit_en,
    input  reg_addr_bus_t         i_commit_addr,
    input  logic [RSID_WIDTH-1:0] i_commit_rsid,
    input  data_bus_t             i_commit_data,
    output rd_resp_t              o_resp
);

    logic w_bypass_hit;

`ifdef REGFILE_COMMIT_BYPASS_EN
    // The committing instruction is still the registered producer: forward its value.
    assign w_bypass_hit = i_commit_en && (i_commit_addr == i_addr) &&
                          (i_tag[i_addr] == i_commit_rsid);
`else
    assign w_bypass_hit = 1'b0;
    logic w_unused_commit;
    assign w_unused_commit = ^{i_commit_en, i_commit_addr, i_commit_rsid, i_commit_data};
`endif

    // Entry lookup; outputs held at zero while in reset or for $0 / disabled port.
    always_comb begin
        o_resp = '0;
        if (i_rst && i_en && (i_addr != REG_ZERO)) begin
            if (i_busy[i_addr] && !w_bypass_hit) begin
                o_resp.is_rsid = 1'b1;
                o_resp.data    = DATA_W'(i_tag[i_addr]);
            end else if (i_busy[i_addr]) begin
                o_resp.data    = i_commit_data;
            end else begin
                o_resp.data    = i_value[i_addr];
            end
        end
    end

endmodule

// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with rename (busy/tag) status.
// Ports: clk, rst (synchronous, active-low), bus (rename_reg_file_if.slave):
//        two combinational read ports, ID allocation, ROB commit, flush.
// Config: REGFILE_COMMIT_BYPASS_EN forwards a same-cycle matching commit to reads.
module rename_reg_file
    import rename_reg_file_pkg::*;
#(
    parameter int unsigned RSID_WIDTH = RSID_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    rename_reg_file_if.slave  bus
);

    data_bus_t             r_value [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;
    logic [RSID_WIDTH-1:0] r_tag   [NUM_REGS];

    rd_resp_t w_resp_1;
    rd_resp_t w_resp_2;

    // Entry state update; $0 is never written so it stays zero and idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_value <= '{default: '0};
            r_tag   <= '{default: '0};
            r_busy  <= '0;
        end else begin
            if (bus.commit_en && (bus.commit_addr != REG_ZERO)) begin
                r_value[bus.commit_addr] <= bus.commit_data;
                // Only the current producer may clear busy; a younger alloc keeps it.
                if (r_busy[bus.commit_addr] && (r_tag[bus.commit_addr] == bus.commit_rsid))
                    r_busy[bus.commit_addr] <= 1'b0;
            end
            // Placed after commit so a same-register alloc wins the busy bit.
            if (bus.alloc_en && !bus.flush && (bus.alloc_addr != REG_ZERO)) begin
                r_busy[bus.alloc_addr] <= 1'b1;
                r_tag[bus.alloc_addr]  <= bus.alloc_rsid;
            end
            if (bus.flush)
                r_busy <= '0;
        end
    end

    reg_read_port #(.RSID_WIDTH(RSID_WIDTH)) u_read_port_1 (
        .i_rst         (rst),
        .i_en          (bus.read_en_1),
        .i_addr        (bus.read_addr_1),
        .i_value       (r_value),
        .i_busy        (r_busy),
        .i_tag         (r_tag),
        .i_commit_en   (bus.commit_en),
        .i_commit_addr (bus.commit_addr),
        .i_commit_rsid (bus.commit_rsid),
        .i_commit_data (bus.commit_data),
        .o_resp        (w_resp_1)
    );

    reg_read_port #(.RSID_WIDTH(RSID_WIDTH)) u_read_port_2 (
        .i_rst         (rst),
        .i_en          (bus.read_en_2),
        .i_addr        (bus.read_addr_2),
        .i_value       (r_value),
        .i_busy        (r_busy),
        .i_tag         (r_tag),
        .i_commit_en   (bus.commit_en),
        .i_commit_addr (bus.commit_addr),
        .i_commit_rsid (bus.commit_rsid),
        .i_commit_data (bus.commit_data),
        .o_resp        (w_resp_2)
    );

    assign bus.read_is_rsid_1 = w_resp_1.is_rsid;
    assign bus.read_data_1    = w_resp_1.data;
    assign bus.read_is_rsid_2 = w_resp_2.is_rsid;
    assign bus.read_data_2    = w_resp_2.data;

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed self-checking bench for rename_reg_file.
module tb_rename_reg_file;

`ifdef REGFILE_COMMIT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rename_reg_file_if #(.RSID_WIDTH(5)) bus_if ();

    rename_reg_file #(.RSID_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got is_rsid=%0b data=%h, expected is_rsid=%0b data=%h",
                     tag, obs[32], obs[31:0], exp[32], exp[31:0]);
        end
    endtask

    function automatic logic [32:0] port1();
        return {bus_if.read_is_rsid_1, bus_if.read_data_1};
    endfunction

    function automatic logic [32:0] port2();
        return {bus_if.read_is_rsid_2, bus_if.read_data_2};
    endfunction

    task automatic idle();
        bus_if.read_en_1   = 1'b0; bus_if.read_addr_1 = '0;
        bus_if.read_en_2   = 1'b0; bus_if.read_addr_2 = '0;
        bus_if.alloc_en    = 1'b0; bus_if.alloc_addr  = '0; bus_if.alloc_rsid = '0;
        bus_if.commit_en   = 1'b0; bus_if.commit_addr = '0;
        bus_if.commit_rsid = '0;   bus_if.commit_data = '0;
        bus_if.flush       = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        bus_if.read_en_1 = 1'b1; bus_if.read_addr_1 = a1;
        bus_if.read_en_2 = 1'b1; bus_if.read_addr_2 = a2;
        #1;
    endtask

    task automatic alloc(input logic [4:0] a, input logic [4:0] rsid);
        bus_if.alloc_en = 1'b1; bus_if.alloc_addr = a; bus_if.alloc_rsid = rsid;
    endtask

    task automatic commit(input logic [4:0] a, input logic [4:0] rsid, input logic [31:0] d);
        bus_if.commit_en = 1'b1; bus_if.commit_addr = a;
        bus_if.commit_rsid = rsid; bus_if.commit_data = d;
    endtask

    // Apply pending inputs at the next edge, then return to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        idle();
        step();
        step();

        // 1. Reset behaviour
        rd(5'd5, 5'd5);
        check("rst_low_p1", port1(), 33'h0);
        check("rst_low_p2", port2(), 33'h0);
        rst = 1'b1;
        step();
        rd(5'd5, 5'd5);
        check("after_rst_p1", port1(), 33'h0);
        check("after_rst_p2", port2(), 33'h0);

        // 2. Commit to a non-busy register
        commit(5'd3, 5'd2, 32'h1234);
        step();
        rd(5'd3, 5'd3);
        check("commit_nb_p1", port1(), {1'b0, 32'h1234});
        check("commit_nb_p2", port2(), {1'b0, 32'h1234});

        // 3. Alloc then matching commit; reads see the pre-alloc mapping
        alloc(5'd4, 5'd7);
        rd(5'd4, 5'd3);
        check("read_before_alloc", port1(), {1'b0, 32'h0});
        step();
        rd(5'd4, 5'd4);
        check("alloc_busy", port1(), {1'b1, 32'd7});
        commit(5'd4, 5'd7, 32'hCAFE);
        #1;
        check("commit_same_cycle", port2(), BYPASS ? {1'b0, 32'hCAFE} : {1'b1, 32'd7});
        step();
        rd(5'd4, 5'd4);
        check("commit_match", port1(), {1'b0, 32'hCAFE});

        // 4. WAW: older producer's commit must not clear busy
        alloc(5'd4, 5'd7);
        step();
        alloc(5'd4, 5'd9);
        step();
        commit(5'd4, 5'd7, 32'h11);
        step();
        rd(5'd4, 5'd4);
        check("waw_stale_commit", port1(), {1'b1, 32'd9});
        commit(5'd4, 5'd9, 32'h22);
        step();
        rd(5'd4, 5'd4);
        check("waw_final_commit", port2(), {1'b0, 32'h22});

        // 5. Flush beats alloc; $0 immutable; alloc+commit same register
        alloc(5'd6, 5'd3);
        bus_if.flush = 1'b1;
        step();
        rd(5'd6, 5'd6);
        check("flush_kills_alloc", port1(), {1'b0, 32'h0});
        alloc(5'd0, 5'd5);
        commit(5'd0, 5'd5, 32'hFFFF);
        step();
        rd(5'd0, 5'd0);
        check("reg0_zero", port1(), 33'h0);
        alloc(5'd8, 5'd4);
        commit(5'd8, 5'd1, 32'h5);
        step();
        rd(5'd8, 5'd8);
        check("alloc_commit_same", port1(), {1'b1, 32'd4});
        commit(5'd8, 5'd4, 32'h77);
        step();
        rd(5'd8, 5'd8);
        check("alloc_commit_value", port2(), {1'b0, 32'h77});

        // Flush clears busy entries, keeps same-cycle commit value
        alloc(5'd10, 5'd6);
        step();
        alloc(5'd11, 5'd8);
        commit(5'd12, 5'd0, 32'hBEEF);
        bus_if.flush = 1'b1;
        step();
        rd(5'd10, 5'd12);
        check("flush_clears_busy", port1(), {1'b0, 32'h0});
        check("flush_keeps_commit", port2(), {1'b0, 32'hBEEF});
        rd(5'd11, 5'd11);
        check("flush_drops_alloc", port1(), {1'b0, 32'h0});

        // Disabled read port returns zero even on a busy register
        alloc(5'd13, 5'd3);
        step();
        rd(5'd13, 5'd13);
        bus_if.read_en_1 = 1'b0;
        #1;
        check("read_disabled", port1(), 33'h0);
        check("read_enabled", port2(), {1'b1, 32'd3});

        // 6. Same-cycle commit bypass
        alloc(5'd9, 5'd5);
        step();
        commit(5'd9, 5'd5, 32'hAA);
        rd(5'd9, 5'd9);
        check("bypass_p1", port1(), BYPASS ? {1'b0, 32'hAA} : {1'b1, 32'd5});
        step();
        rd(5'd9, 5'd9);
        check("bypass_after", port1(), {1'b0, 32'hAA});

        // Tag-mismatched commit never bypasses and leaves busy set
        alloc(5'd14, 5'd2);
        step();
        commit(5'd14, 5'd3, 32'h33);
        rd(5'd14, 5'd14);
        check("no_bypass_mismatch", port1(), {1'b1, 32'd2});
        step();
        rd(5'd14, 5'd14);
        check("mismatch_stays_busy", port2(), {1'b1, 32'd2});

        // Mid-operation reset: outputs drop immediately and pending state is lost
        rst = 1'b0;
        rd(5'd3, 5'd13);
        check("midrst_p1", port1(), 33'h0);
        check("midrst_p2", port2(), 33'h0);
        step();
        rst = 1'b1;
        rd(5'd3, 5'd13);
        check("post_rst_value", port1(), 33'h0);
        check("post_rst_busy", port2(), 33'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
